// File: rtl/qm_control_issue.sv
// qm_control_issue: registered decode/issue control stage for the q3kmips pipeline.
// Decodes opcode/funct into the execute-stage control bundle and registers it.
// Stalls the incoming instruction on load-use and HI/LO hazards.
// Tracks the multi-cycle MULT/DIV unit with a down-counting busy counter.
module qm_control_issue #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Valid,
  input  logic [5:0] i_Opcode,
  input  logic [5:0] i_Function,
  input  logic [4:0] i_Rs,
  input  logic [4:0] i_Rt,
  input  logic [4:0] i_Rd,
  input  logic       i_Hold,
  input  logic       i_Flush,
  output logic       o_Ready,
  output logic       co_Valid,
  output logic       co_RegDest,
  output logic       co_ALUSource,
  output logic [3:0] co_ALUControl,
  output logic       co_MemWrite,
  output logic       co_RegWSource,
  output logic       co_RegWrite,
  output logic [4:0] co_DestReg,
  output logic       co_MulDivStart,
  output logic       co_Illegal,
  output logic       co_MulDivBusy
);

  // ALU operation codes shared with the execute stage
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTIU = 4'd7;
  localparam logic [3:0] ALU_MUL   = 4'd8;
  localparam logic [3:0] ALU_DIV   = 4'd9;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  // SPECIAL function codes
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

  // Decoded (combinational) bundle for the incoming instruction
  logic       dec_reg_dest;
  logic       dec_alu_src;
  logic [3:0] dec_alu_ctrl;
  logic       dec_mem_write;
  logic       dec_regw_src;
  logic       dec_reg_write;
  logic       dec_muldiv_start;
  logic       dec_is_div;
  logic       dec_illegal;
  logic       dec_uses_hilo;
  logic       dec_rt_is_src;
  logic [4:0] dec_dest_reg;

  // Registered execute-stage bundle
  logic       valid_q,        valid_d;
  logic       reg_dest_q,     reg_dest_d;
  logic       alu_src_q,      alu_src_d;
  logic [3:0] alu_ctrl_q,     alu_ctrl_d;
  logic       mem_write_q,    mem_write_d;
  logic       regw_src_q,     regw_src_d;
  logic       reg_write_q,    reg_write_d;
  logic [4:0] dest_reg_q,     dest_reg_d;
  logic       muldiv_start_q, muldiv_start_d;
  logic       illegal_q,      illegal_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic load_use;
  logic muldiv_busy;
  logic hilo;
  logic ready;
  logic accept;

  // Instruction decode: opcode/funct to control bundle, unknown encodings flagged illegal
  always_comb begin
    dec_reg_dest     = 1'b0;
    dec_alu_src      = 1'b0;
    dec_alu_ctrl     = ALU_ADD;
    dec_mem_write    = 1'b0;
    dec_regw_src     = 1'b0;
    dec_reg_write    = 1'b0;
    dec_muldiv_start = 1'b0;
    dec_is_div       = 1'b0;
    dec_illegal      = 1'b0;
    dec_uses_hilo    = 1'b0;
    dec_rt_is_src    = 1'b0;
    case (i_Opcode)
      OP_SPECIAL: begin
        // R-type reads rt as a source operand
        dec_rt_is_src = 1'b1;
        case (i_Function)
          FN_ADD, FN_ADDU: begin dec_reg_dest = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_ADD; end
          FN_SUB, FN_SUBU: begin dec_reg_dest = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_SUB; end
          FN_AND:          begin dec_reg_dest = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_AND; end
          FN_OR:           begin dec_reg_dest = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_OR;  end
          FN_XOR:          begin dec_reg_dest = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_XOR; end
          FN_NOR:          begin dec_reg_dest = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_NOR; end
          FN_SLT:          begin dec_reg_dest = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_SLT; end
          FN_MULT, FN_MULTU: begin
            dec_muldiv_start = 1'b1;
            dec_alu_ctrl     = ALU_MUL;
            dec_uses_hilo    = 1'b1;
          end
          FN_DIV, FN_DIVU: begin
            dec_muldiv_start = 1'b1;
            dec_is_div       = 1'b1;
            dec_alu_ctrl     = ALU_DIV;
            dec_uses_hilo    = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            dec_reg_dest  = 1'b1;
            dec_reg_write = 1'b1;
            dec_alu_ctrl  = ALU_ADD;
            dec_uses_hilo = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_ADD;   end
      OP_SLTI:           begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_SLT;   end
      OP_SLTIU:          begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_SLTIU; end
      OP_ANDI:           begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_AND;   end
      OP_ORI:            begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_OR;    end
      OP_XORI:           begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_XOR;   end
      OP_LW: begin
        dec_alu_src   = 1'b1;
        dec_alu_ctrl  = ALU_ADD;
        dec_regw_src  = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_SW: begin
        // Store data comes from rt, so rt is a source here too
        dec_alu_src   = 1'b1;
        dec_alu_ctrl  = ALU_ADD;
        dec_mem_write = 1'b1;
        dec_rt_is_src = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    dec_dest_reg = dec_reg_dest ? i_Rd : i_Rt;
  end

  // Hazard detection and accept handshake
  always_comb begin
    // Only LW sets the memory writeback source, so it identifies a load in execute
    load_use = valid_q && regw_src_q && (dest_reg_q != 5'd0) &&
               ((i_Rs == dest_reg_q) || (dec_rt_is_src && (i_Rt == dest_reg_q)));
    // A start sitting in the register has not loaded the counter's effect yet downstream
    muldiv_busy = (cnt_q != '0) || (valid_q && muldiv_start_q);
    hilo        = dec_uses_hilo && muldiv_busy;
    ready       = !i_Hold && !i_Flush && !load_use && !hilo;
    accept      = i_Valid && ready;
  end

  // Output register next state: flush beats hold, hold beats load, otherwise bubble
  always_comb begin
    valid_d        = valid_q;
    reg_dest_d     = reg_dest_q;
    alu_src_d      = alu_src_q;
    alu_ctrl_d     = alu_ctrl_q;
    mem_write_d    = mem_write_q;
    regw_src_d     = regw_src_q;
    reg_write_d    = reg_write_q;
    dest_reg_d     = dest_reg_q;
    muldiv_start_d = muldiv_start_q;
    illegal_d      = illegal_q;
    if (i_Flush || (!i_Hold && !accept)) begin
      valid_d        = 1'b0;
      reg_dest_d     = 1'b0;
      alu_src_d      = 1'b0;
      alu_ctrl_d     = 4'd0;
      mem_write_d    = 1'b0;
      regw_src_d     = 1'b0;
      reg_write_d    = 1'b0;
      dest_reg_d     = 5'd0;
      muldiv_start_d = 1'b0;
      illegal_d      = 1'b0;
    end else if (!i_Hold) begin
      valid_d        = 1'b1;
      reg_dest_d     = dec_reg_dest;
      alu_src_d      = dec_alu_src;
      alu_ctrl_d     = dec_alu_ctrl;
      mem_write_d    = dec_mem_write;
      regw_src_d     = dec_regw_src;
      reg_write_d    = dec_reg_write;
      dest_reg_d     = dec_dest_reg;
      muldiv_start_d = dec_muldiv_start;
      illegal_d      = dec_illegal;
    end
  end

  // Busy counter: load on accepted MULT/DIV, otherwise count down; hold/flush do not stop it
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_muldiv_start) begin
      cnt_d = dec_is_div ? DIV_LOAD : MUL_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      valid_q        <= 1'b0;
      reg_dest_q     <= 1'b0;
      alu_src_q      <= 1'b0;
      alu_ctrl_q     <= 4'd0;
      mem_write_q    <= 1'b0;
      regw_src_q     <= 1'b0;
      reg_write_q    <= 1'b0;
      dest_reg_q     <= 5'd0;
      muldiv_start_q <= 1'b0;
      illegal_q      <= 1'b0;
      cnt_q          <= '0;
    end else begin
      valid_q        <= valid_d;
      reg_dest_q     <= reg_dest_d;
      alu_src_q      <= alu_src_d;
      alu_ctrl_q     <= alu_ctrl_d;
      mem_write_q    <= mem_write_d;
      regw_src_q     <= regw_src_d;
      reg_write_q    <= reg_write_d;
      dest_reg_q     <= dest_reg_d;
      muldiv_start_q <= muldiv_start_d;
      illegal_q      <= illegal_d;
      cnt_q          <= cnt_d;
    end
  end

  assign o_Ready        = ready;
  assign co_Valid       = valid_q;
  assign co_RegDest     = reg_dest_q;
  assign co_ALUSource   = alu_src_q;
  assign co_ALUControl  = alu_ctrl_q;
  assign co_MemWrite    = mem_write_q;
  assign co_RegWSource  = regw_src_q;
  assign co_RegWrite    = reg_write_q;
  assign co_DestReg     = dest_reg_q;
  assign co_MulDivStart = muldiv_start_q;
  assign co_Illegal     = illegal_q;
  assign co_MulDivBusy  = (cnt_q != '0);

endmodule

// File: tb/tb_qm_control_issue.sv
// Directed testbench for qm_control_issue: decode table vectors plus
// load-use, HI/LO, hold/flush and mid-operation reset sequences.
module tb_qm_control_issue;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTIU = 4'd7,
                         ALU_MUL = 4'd8, ALU_DIV = 4'd9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_Valid, i_Hold, i_Flush;
  logic [5:0] i_Opcode, i_Function;
  logic [4:0] i_Rs, i_Rt, i_Rd;
  logic       o_Ready, co_Valid, co_RegDest, co_ALUSource, co_MemWrite, co_RegWSource;
  logic       co_RegWrite, co_MulDivStart, co_Illegal, co_MulDivBusy;
  logic [3:0] co_ALUControl;
  logic [4:0] co_DestReg;

  int tests = 0;
  int fails = 0;

  qm_control_issue #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Valid(i_Valid), .i_Opcode(i_Opcode),
    .i_Function(i_Function), .i_Rs(i_Rs), .i_Rt(i_Rt), .i_Rd(i_Rd),
    .i_Hold(i_Hold), .i_Flush(i_Flush), .o_Ready(o_Ready), .co_Valid(co_Valid),
    .co_RegDest(co_RegDest), .co_ALUSource(co_ALUSource), .co_ALUControl(co_ALUControl),
    .co_MemWrite(co_MemWrite), .co_RegWSource(co_RegWSource), .co_RegWrite(co_RegWrite),
    .co_DestReg(co_DestReg), .co_MulDivStart(co_MulDivStart), .co_Illegal(co_Illegal),
    .co_MulDivBusy(co_MulDivBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [16:0] exp;   // {valid,regdest,alusrc,alu[3:0],memwr,wsrc,regwr,dest[4:0],start,illegal}
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(string name, logic [5:0] op, logic [5:0] fn, logic [4:0] rs,
                              logic [4:0] rt, logic [4:0] rd, logic rdst, logic asrc,
                              logic [3:0] alu, logic mw, logic wsrc, logic rw,
                              logic [4:0] dst, logic ill);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.rs = rs; v.rt = rt; v.rd = rd;
    v.exp = {1'b1, rdst, asrc, alu, mw, wsrc, rw, dst, 1'b0, ill};
    return v;
  endfunction

  function automatic logic [16:0] bundle();
    return {co_Valid, co_RegDest, co_ALUSource, co_ALUControl, co_MemWrite, co_RegWSource,
            co_RegWrite, co_DestReg, co_MulDivStart, co_Illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    i_Valid = v; i_Opcode = op; i_Function = fn; i_Rs = rs; i_Rt = rt; i_Rd = rd;
  endtask

  // Present a start/read pair and measure how long the read is held off
  task automatic run_muldiv(input string name, input logic [5:0] fn_start,
                            input logic [5:0] fn_read, input logic [3:0] alu, input int cycles);
    int stall;
    @(negedge clk); drive(1, 6'h00, fn_start, 5'd1, 5'd2, 5'd0);
    #1 chk({name, " start ready"}, o_Ready, 1);
    @(posedge clk); #1;
    chk({name, " start bundle"}, {co_Valid, co_MulDivStart, co_ALUControl, co_RegWrite, co_MulDivBusy},
        {1'b1, 1'b1, alu, 1'b0, 1'b1});
    @(negedge clk); drive(1, 6'h00, fn_read, 5'd0, 5'd0, 5'd8);
    #1;
    stall = 0;
    while (!o_Ready && stall < 100) begin
      stall++;
      @(posedge clk); #1;
      if (stall == 1) chk({name, " start pulse"}, {co_Valid, co_MulDivStart}, 2'b00);
    end
    chk({name, " stall cycles"}, stall, cycles);
    chk({name, " busy clear"}, co_MulDivBusy, 0);
    @(posedge clk); #1;
    chk({name, " read issue"}, bundle(), {1'b1, 1'b1, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0});
    $display("[TB] %s: read held %0d cycles", name, stall);
    @(negedge clk); i_Valid = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk("ADDU",  6'h00, 6'b100001, 5'd1, 5'd2,  5'd5,  1, 0, ALU_ADD,   0, 0, 1, 5'd5,  0);
    vecs[1]  = mk("ADD",   6'h00, 6'b100000, 5'd1, 5'd2,  5'd6,  1, 0, ALU_ADD,   0, 0, 1, 5'd6,  0);
    vecs[2]  = mk("SUB",   6'h00, 6'b100010, 5'd1, 5'd2,  5'd7,  1, 0, ALU_SUB,   0, 0, 1, 5'd7,  0);
    vecs[3]  = mk("SUBU",  6'h00, 6'b100011, 5'd1, 5'd2,  5'd8,  1, 0, ALU_SUB,   0, 0, 1, 5'd8,  0);
    vecs[4]  = mk("AND",   6'h00, 6'b100100, 5'd1, 5'd2,  5'd9,  1, 0, ALU_AND,   0, 0, 1, 5'd9,  0);
    vecs[5]  = mk("OR",    6'h00, 6'b100101, 5'd1, 5'd2,  5'd10, 1, 0, ALU_OR,    0, 0, 1, 5'd10, 0);
    vecs[6]  = mk("XOR",   6'h00, 6'b100110, 5'd1, 5'd2,  5'd11, 1, 0, ALU_XOR,   0, 0, 1, 5'd11, 0);
    vecs[7]  = mk("NOR",   6'h00, 6'b100111, 5'd1, 5'd2,  5'd12, 1, 0, ALU_NOR,   0, 0, 1, 5'd12, 0);
    vecs[8]  = mk("SLT",   6'h00, 6'b101010, 5'd1, 5'd2,  5'd13, 1, 0, ALU_SLT,   0, 0, 1, 5'd13, 0);
    vecs[9]  = mk("MFHI",  6'h00, 6'b010000, 5'd0, 5'd0,  5'd14, 1, 0, ALU_ADD,   0, 0, 1, 5'd14, 0);
    vecs[10] = mk("MFLO",  6'h00, 6'b010010, 5'd0, 5'd0,  5'd15, 1, 0, ALU_ADD,   0, 0, 1, 5'd15, 0);
    vecs[11] = mk("ADDI",  6'b001000, 6'h3f, 5'd1, 5'd12, 5'd13, 0, 1, ALU_ADD,   0, 0, 1, 5'd12, 0);
    vecs[12] = mk("ADDIU", 6'b001001, 6'h00, 5'd1, 5'd3,  5'd13, 0, 1, ALU_ADD,   0, 0, 1, 5'd3,  0);
    vecs[13] = mk("SLTI",  6'b001010, 6'h00, 5'd1, 5'd4,  5'd13, 0, 1, ALU_SLT,   0, 0, 1, 5'd4,  0);
    vecs[14] = mk("SLTIU", 6'b001011, 6'h00, 5'd1, 5'd5,  5'd13, 0, 1, ALU_SLTIU, 0, 0, 1, 5'd5,  0);
    vecs[15] = mk("ANDI",  6'b001100, 6'h00, 5'd1, 5'd6,  5'd13, 0, 1, ALU_AND,   0, 0, 1, 5'd6,  0);
    vecs[16] = mk("ORI",   6'b001101, 6'h00, 5'd1, 5'd7,  5'd13, 0, 1, ALU_OR,    0, 0, 1, 5'd7,  0);
    vecs[17] = mk("XORI",  6'b001110, 6'h00, 5'd1, 5'd8,  5'd13, 0, 1, ALU_XOR,   0, 0, 1, 5'd8,  0);
    vecs[18] = mk("LW",    6'b100011, 6'h00, 5'd1, 5'd20, 5'd13, 0, 1, ALU_ADD,   0, 1, 1, 5'd20, 0);
    vecs[19] = mk("SW",    6'b101011, 6'h00, 5'd1, 5'd13, 5'd2,  0, 1, ALU_ADD,   1, 0, 0, 5'd13, 0);
    vecs[20] = mk("ILLOP", 6'b111111, 6'h00, 5'd1, 5'd14, 5'd15, 0, 0, ALU_ADD,   0, 0, 0, 5'd14, 1);
    vecs[21] = mk("ILLFN", 6'h00, 6'b000000, 5'd1, 5'd14, 5'd15, 0, 0, ALU_ADD,   0, 0, 0, 5'd14, 1);

    rst_n = 0; i_Hold = 0; i_Flush = 0;
    drive(0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    #1;
    chk("reset outputs", {bundle(), co_MulDivBusy}, 18'd0);
    chk("reset ready", o_Ready, 1);
    #11 rst_n = 1;

    // Decode table, one instruction per cycle
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(1, vecs[i].op, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      #1 chk({vecs[i].name, " ready"}, o_Ready, 1);
      @(posedge clk); #1;
      chk({vecs[i].name, " bundle"}, bundle(), vecs[i].exp);
      $display("[TB] %s op=%b fn=%b -> bundle=%h", vecs[i].name, vecs[i].op, vecs[i].fn, bundle());
    end
    @(negedge clk); i_Valid = 0;
    @(posedge clk); #1;
    chk("idle bubble", bundle(), 17'd0);

    // Load-use on rs: one stall cycle, one bubble, then issue
    @(negedge clk); drive(1, 6'b100011, 6'h00, 5'd1, 5'd3, 5'd0);
    @(posedge clk); #1;
    @(negedge clk); drive(1, 6'h00, 6'b100001, 5'd3, 5'd1, 5'd6);
    #1 chk("loaduse rs ready", o_Ready, 0);
    @(posedge clk); #1;
    chk("loaduse bubble", co_Valid, 0);
    chk("loaduse ready again", o_Ready, 1);
    @(posedge clk); #1;
    chk("loaduse issue", bundle(), {1'b1, 1'b1, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0});
    $display("[TB] load-use rs=3 after LW rt=3 handled");

    // Load-use on rt of an R-type
    @(negedge clk); drive(1, 6'b100011, 6'h00, 5'd1, 5'd3, 5'd0);
    @(posedge clk); #1;
    @(negedge clk); drive(1, 6'h00, 6'b100001, 5'd1, 5'd3, 5'd6);
    #1 chk("loaduse rt ready", o_Ready, 0);
    // An I-type's rt is a destination, not a source: no stall
    drive(1, 6'b001101, 6'h00, 5'd1, 5'd3, 5'd0);
    #1 chk("loaduse itype rt ready", o_Ready, 1);
    i_Valid = 0;
    @(posedge clk); #1;

    // LW to $0 never stalls
    @(negedge clk); drive(1, 6'b100011, 6'h00, 5'd1, 5'd0, 5'd0);
    @(posedge clk); #1;
    @(negedge clk); drive(1, 6'h00, 6'b100001, 5'd0, 5'd0, 5'd6);
    #1 chk("loaduse r0 ready", o_Ready, 1);
    @(posedge clk); #1;
    chk("loaduse r0 issue", {co_Valid, co_DestReg}, {1'b1, 5'd6});
    @(negedge clk); i_Valid = 0;
    @(posedge clk); #1;

    run_muldiv("MULT/MFLO", 6'b011000, 6'b010010, ALU_MUL, 4);
    run_muldiv("DIV/MFHI",  6'b011010, 6'b010000, ALU_DIV, 32);

    // Hold freezes an ORI for three cycles, then flush during hold bubbles it
    @(negedge clk); drive(1, 6'b001101, 6'h00, 5'd1, 5'd4, 5'd0);
    @(posedge clk); #1;
    @(negedge clk); i_Hold = 1; drive(1, 6'h00, 6'b100001, 5'd1, 5'd2, 5'd5);
    for (int c = 0; c < 3; c++) begin
      #1 chk("hold ready", o_Ready, 0);
      @(posedge clk); #1;
      chk("hold bundle", bundle(), {1'b1, 1'b0, 1'b1, ALU_OR, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0});
      @(negedge clk);
    end
    i_Flush = 1;
    #1 chk("flush ready", o_Ready, 0);
    @(posedge clk); #1;
    chk("flush over hold", bundle(), 17'd0);
    $display("[TB] hold x3 then flush handled");
    @(negedge clk); i_Hold = 0; i_Flush = 0; i_Valid = 0;

    // Flush does not cancel a running multiply
    @(negedge clk); drive(1, 6'h00, 6'b011001, 5'd1, 5'd2, 5'd0);
    @(posedge clk); #1;
    @(negedge clk); i_Valid = 0; i_Flush = 1;
    @(posedge clk); #1;
    chk("flush keeps busy", {co_Valid, co_MulDivBusy}, 2'b01);
    @(negedge clk); i_Flush = 0;
    repeat (6) @(posedge clk);

    // Reset in the middle of a divide
    @(negedge clk); drive(1, 6'h00, 6'b011011, 5'd1, 5'd2, 5'd0);
    @(posedge clk); #1;
    @(negedge clk); i_Valid = 0;
    repeat (15) @(posedge clk);
    #1 chk("div busy before reset", co_MulDivBusy, 1);
    #2 rst_n = 0;
    #1 chk("async reset outputs", {bundle(), co_MulDivBusy}, 18'd0);
    #3 rst_n = 1;
    drive(1, 6'h00, 6'b010000, 5'd0, 5'd0, 5'd9);
    #1 chk("post reset MFHI ready", o_Ready, 1);
    @(posedge clk); #1;
    chk("post reset MFHI issue", {co_Valid, co_DestReg, co_RegWrite, co_MulDivBusy}, {1'b1, 5'd9, 1'b1, 1'b0});
    $display("[TB] reset mid-DIV then MFHI handled");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qm_control_issue.md
Name: qm_control_issue

Overview:
Registered decode/issue control stage for the q3kmips pipeline. It decodes opcode/funct into the control bundle, registers it into the execute stage, and detects load-use and HI/LO hazards. It also sequences a multi-cycle MULT/DIV unit with a busy counter. It replaces the purely combinational control decoder and sits between decode and execute.

Parameters:
MUL_CYCLES, 4, cycles MULT/MULTU occupies the mul/div unit (>=1)
DIV_CYCLES, 32, cycles DIV/DIVU occupies the mul/div unit (>=1)
CNT_W, 6, busy-counter width; must hold max(MUL_CYCLES, DIV_CYCLES)

Ports:
i_Clock  in  1  clock, rising edge
i_Reset_n  in  1  asynchronous reset, active low
i_Valid  in  1  decode stage presents an instruction
i_Opcode  in  6  instruction [31:26]
i_Function  in  6  instruction [5:0]
i_Rs  in  5  source register rs
i_Rt  in  5  source/dest register rt
i_Rd  in  5  dest register rd
i_Hold  in  1  execute stage cannot advance; freezes the output register
i_Flush  in  1  branch redirect; squashes the output register and incoming instruction
o_Ready  out  1  instruction accepted this cycle when i_Valid && o_Ready
co_Valid  out  1  registered bundle holds a real instruction
co_RegDest  out  1  0=RT, 1=RD
co_ALUSource  out  1  0=RT value, 1=immediate
co_ALUControl  out  4  ALU_* code from defines.v
co_MemWrite  out  1  store
co_RegWSource  out  1  0=ALU, 1=memory
co_RegWrite  out  1  register writeback enable
co_DestReg  out  5  selected destination register (rd or rt)
co_MulDivStart  out  1  start mul/div unit; co_ALUControl=ALU_MUL or ALU_DIV
co_Illegal  out  1  reserved/undecoded instruction issued
co_MulDivBusy  out  1  mul/div counter nonzero

Behaviour:
- Reset (async, i_Reset_n=0): all co_* outputs 0; busy counter 0. o_Ready = !i_Hold after reset.
- Decode table, all other control bits 0:
  - SPECIAL ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT: RegDest=1, RegWrite=1, matching ALU_* code.
  - MULT/MULTU: MulDivStart=1, ALU_MUL. DIV/DIVU: MulDivStart=1, ALU_DIV. Both have RegWrite=0.
  - MFHI (010000) / MFLO (010010): RegDest=1, RegWrite=1, ALUControl=ALU_ADD.
  - ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU: ALUSource=1, RegWrite=1, RegDest=0, matching code (SLTIU → ALU_SLTIU).
  - LW: ALUSource=1, ALU_ADD, RegWSource=1, RegWrite=1. SW: ALUSource=1, ALU_ADD, MemWrite=1.
  - Anything else: co_Illegal=1, no writes.
  - co_DestReg = RegDest ? i_Rd : i_Rt.
- Hazards, evaluated combinationally:
  - Load-use: co_Valid, current bundle is LW, co_DestReg!=0, and incoming rs==co_DestReg, or incoming rt==co_DestReg for SPECIAL/SW.
  - HI/LO: incoming is MFHI/MFLO/MULT*/DIV* and the mul/div unit is busy, i.e. co_MulDivBusy=1 or co_MulDivStart=1 with co_Valid.
- o_Ready = !i_Hold && !i_Flush && !loaduse && !hilo.
- Output register, each edge:
  - If i_Flush: bubble (co_Valid=0, all control 0). Flush has priority over hold.
  - Else if i_Hold: unchanged.
  - Else if accept: load the decoded bundle with co_Valid=1.
  - Else: bubble.
- Latency: one cycle from accept to co_*.
- Busy counter:
  - On accept of MULT*/DIV*, load MUL_CYCLES or DIV_CYCLES.
  - Otherwise decrement while nonzero, independent of i_Hold and i_Flush. Flush never cancels a running op.
  - co_MulDivBusy = counter!=0.
  - MFHI/MFLO issues on the first cycle the counter reads 0.
- Reset mid-operation: counter and bundle cleared immediately.

Test Plan:
- ADDU (op 0, funct 100001, rd=5), accept → next cycle co_Valid=1, RegDest=1, RegWrite=1, DestReg=5, ALUControl=ALU_ADD.
- LW rt=3, then ADDU rs=3 → o_Ready=0 for exactly one cycle, one bubble, ADDU issues on the following edge. Repeat with rt=0 → no stall.
- MULT, then MFLO, MUL_CYCLES=4 → co_MulDivStart pulses one cycle; MFLO is held while co_MulDivBusy=1 and issues when the counter reaches 0. Repeat with DIV and DIV_CYCLES=32.
- i_Hold high 3 cycles with an ORI in the register → co_* stable and o_Ready=0. Assert i_Flush during hold → co_Valid=0 next edge.
- Opcode 111111 → co_Illegal=1, RegWrite=0, MemWrite=0, co_Valid=1.
- Pull i_Reset_n low mid-DIV (counter=17) → all outputs and co_MulDivBusy 0 asynchronously; MFHI accepted immediately after release.
